neo_strip_arbiter: RTL and testbench

//  Round-robin arbiter that shares one NeoPixel strip controller between
//  NUM_REQ pattern producers. It grants one producer at a time and muxes

---
 rtl/neo_strip_arbiter.sv | 170 +++++++++++++++++
 tb/tb_neo_strip_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/neo_strip_arbiter.sv
// Round-robin arbiter sharing one NeoPixel strip controller between NUM_REQ producers.
// Muxes the owner's load/send bus, gates handshakes back to it and revokes stalled grants.
module neo_strip_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned NUM_PIX = 5,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   p_load_color,
    input  logic [NUM_REQ*3-1:0] p_pixel_index,
    input  logic [NUM_REQ*2-1:0] p_color_index,
    input  logic [NUM_REQ*8-1:0] p_color_level,
    input  logic [NUM_REQ-1:0]   p_send_it,
    input  logic                 ready_to_load,
    input  logic                 ready_to_send,
    input  logic                 done_wait,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   g_ready_to_load,
    output logic [NUM_REQ-1:0]   g_ready_to_send,
    output logic [NUM_REQ-1:0]   g_done,
    output logic                 load_color,
    output logic [2:0]           pixel_index,
    output logic [1:0]           color_index,
    output logic [7:0]           color_level,
    output logic                 send_it,
    output logic                 bad_pixel,
    output logic                 timeout_err
);
    localparam int unsigned IdxW     = (NUM_REQ > 2) ? 2 : 1;
    localparam int unsigned WdW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]  PixLimit = 4'(NUM_PIX);

    typedef enum logic [1:0] {StIdle, StGrant, StSending, StRelease} state_t;

    state_t              r_state, w_state_next;
    logic [NUM_REQ-1:0]  r_grant, w_grant_next;
    logic [IdxW-1:0]     r_owner, w_owner_next;
    logic [IdxW-1:0]     r_rr, w_rr_next;
    logic [WdW-1:0]      r_wdog, w_wdog_next;

    logic                w_found_hi, w_found_any;
    logic [IdxW-1:0]     w_pick_hi, w_pick_any, w_pick;
    logic                w_own_load, w_own_send;
    logic [2:0]          w_own_pix;
    logic [1:0]          w_own_col;
    logic [7:0]          w_own_lvl;
    logic                w_in_grant, w_send, w_load_try, w_pix_ok;
    logic                w_owner_req, w_wdog_fire, w_timeout;

    // Lowest set req at or above the pointer wins; otherwise wrap to the lowest set req.
    always_comb begin
        w_found_hi  = 1'b0;
        w_found_any = 1'b0;
        w_pick_hi   = '0;
        w_pick_any  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                w_found_any = 1'b1;
                w_pick_any  = IdxW'(j);
                if (IdxW'(j) >= r_rr) begin
                    w_found_hi = 1'b1;
                    w_pick_hi  = IdxW'(j);
                end
            end
        end
        w_pick = w_found_hi ? w_pick_hi : w_pick_any;
    end

    always_comb begin
        w_own_load = 1'b0;
        w_own_send = 1'b0;
        w_own_pix  = '0;
        w_own_col  = '0;
        w_own_lvl  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_owner == IdxW'(j)) begin
                w_own_load = p_load_color[j];
                w_own_send = p_send_it[j];
                w_own_pix  = p_pixel_index[3*j +: 3];
                w_own_col  = p_color_index[2*j +: 2];
                w_own_lvl  = p_color_level[8*j +: 8];
            end
        end
    end

    assign w_in_grant  = (r_state == StGrant);
    assign w_send      = w_in_grant & w_own_send & ready_to_send;
    // A send in the same cycle takes precedence over any load.
    assign w_load_try  = w_in_grant & w_own_load & ready_to_load & ~w_send;
    assign w_pix_ok    = ({1'b0, w_own_pix} < PixLimit);
    assign w_owner_req = |(req & r_grant);
    assign w_wdog_fire = (r_wdog == WdW'(TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_owner_next = r_owner;
        w_rr_next    = r_rr;
        w_wdog_next  = r_wdog;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_found_any) begin
                    w_state_next = StGrant;
                    w_owner_next = w_pick;
                    w_grant_next = NUM_REQ'(1) << w_pick;
                    w_wdog_next  = '0;
                end
            end
            StGrant: begin
                w_wdog_next = r_wdog + WdW'(1);
                if (w_send) begin
                    w_state_next = StSending;
                end else if (!w_owner_req) begin
                    w_state_next = StRelease;
                    w_grant_next = '0;
                end else if (w_wdog_fire) begin
                    w_timeout    = 1'b1;
                    w_state_next = StRelease;
                    w_grant_next = '0;
                end
            end
            StSending: begin
                if (done_wait) begin
                    w_state_next = StRelease;
                    w_grant_next = '0;
                end
            end
            StRelease: begin
                w_state_next = StIdle;
                w_rr_next    = (r_owner == IdxW'(NUM_REQ - 1)) ? '0 : r_owner + IdxW'(1);
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_owner <= '0;
            r_rr    <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_owner <= w_owner_next;
            r_rr    <= w_rr_next;
            r_wdog  <= w_wdog_next;
        end
    end

    // The bus and handshakes are live only in GRANT; outside it everything reads 0.
    always_comb begin
        grant           = r_grant;
        g_ready_to_load = w_in_grant ? (r_grant & {NUM_REQ{ready_to_load}}) : '0;
        g_ready_to_send = w_in_grant ? (r_grant & {NUM_REQ{ready_to_send}}) : '0;
        g_done          = ((r_state == StSending) && done_wait) ? r_grant : '0;
        load_color      = w_load_try & w_pix_ok;
        bad_pixel       = w_load_try & ~w_pix_ok;
        send_it         = w_send;
        pixel_index     = w_in_grant ? w_own_pix : '0;
        color_index     = w_in_grant ? w_own_col : '0;
        color_level     = w_in_grant ? w_own_lvl : '0;
        timeout_err     = w_timeout;
    end

endmodule

// File: tb/tb_neo_strip_arbiter.sv
// Directed bench for neo_strip_arbiter: scoreboarded load bus plus grant/handshake checks.
module tb_neo_strip_arbiter;
    localparam int unsigned NR = 2;
    localparam int unsigned NP = 5;
    localparam int unsigned TO = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req, p_load_color, p_send_it;
    logic [NR*3-1:0]   p_pixel_index;
    logic [NR*2-1:0]   p_color_index;
    logic [NR*8-1:0]   p_color_level;
    logic              ready_to_load, ready_to_send, done_wait;
    logic [NR-1:0]     grant, g_ready_to_load, g_ready_to_send, g_done;
    logic              load_color, send_it, bad_pixel, timeout_err;
    logic [2:0]        pixel_index;
    logic [1:0]        color_index;
    logic [7:0]        color_level;
    logic [24:0]       all_outs;
    logic [12:0]       mon_obs;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_loads = 0;
    int n_sends = 0;
    logic [12:0] exp_q[$];

    neo_strip_arbiter #(.NUM_REQ(NR), .NUM_PIX(NP), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .req(req),
        .p_load_color(p_load_color), .p_pixel_index(p_pixel_index),
        .p_color_index(p_color_index), .p_color_level(p_color_level),
        .p_send_it(p_send_it), .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send), .done_wait(done_wait),
        .grant(grant), .g_ready_to_load(g_ready_to_load),
        .g_ready_to_send(g_ready_to_send), .g_done(g_done),
        .load_color(load_color), .pixel_index(pixel_index),
        .color_index(color_index), .color_level(color_level),
        .send_it(send_it), .bad_pixel(bad_pixel), .timeout_err(timeout_err)
    );

    assign all_outs = {grant, g_ready_to_load, g_ready_to_send, g_done, load_color,
                       pixel_index, color_index, color_level, send_it, bad_pixel,
                       timeout_err};

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_p(input int p, input logic ld, input logic snd, input logic [2:0] pix,
                         input logic [1:0] col, input logic [7:0] lvl);
        p_load_color[p]          = ld;
        p_send_it[p]             = snd;
        p_pixel_index[p*3 +: 3]  = pix;
        p_color_index[p*2 +: 2]  = col;
        p_color_level[p*8 +: 8]  = lvl;
    endtask

    task automatic push(input logic [2:0] pix, input logic [1:0] col, input logic [7:0] lvl);
        exp_q.push_back({pix, col, lvl});
    endtask

    // Every forwarded load must match the oldest expected owner load.
    always @(negedge clock) begin
        if (!reset) begin
            if (load_color) begin
                n_loads++;
                mon_obs = {pixel_index, color_index, color_level};
                if (exp_q.size() == 0) chk("load_unexpected", 32'(load_color), 32'd0);
                else chk("load_data", 32'(mon_obs), 32'(exp_q.pop_front()));
            end
            if (send_it) n_sends++;
        end
    end

    initial begin
        reset = 1'b1; req = '0; p_load_color = '0; p_send_it = '0;
        p_pixel_index = '0; p_color_index = '0; p_color_level = '0;
        ready_to_load = 1'b1; ready_to_send = 1'b1; done_wait = 1'b0;
        set_p(0, 1'b1, 1'b1, 3'd1, 2'd1, 8'hAA);
        set_p(1, 1'b1, 1'b1, 3'd2, 2'd2, 8'hBB);
        #2; chk("reset_outputs", 32'(all_outs), 32'd0);
        req = 2'b11;
        tick(); chk("reset_held", 32'(all_outs), 32'd0);
        set_p(0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
        set_p(1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
        req = 2'b00;
        reset = 1'b0;

        // 1: single producer, 15 loads then send.
        tick(); req = 2'b01; #3; chk("t1_idle_grant", 32'(grant), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            set_p(0, 1'b1, 1'b0, 3'(i % 5), 2'(i % 3), 8'(i * 17 + 1));
            push(3'(i % 5), 2'(i % 3), 8'(i * 17 + 1));
            #3;
            chk("t1_grant", 32'(grant), 32'd1);
            chk("t1_gated_rdy", 32'({g_ready_to_load, g_ready_to_send}), 32'b0101);
            chk("t1_load", 32'(load_color), 32'd1);
        end
        tick(); set_p(0, 1'b0, 1'b1, 3'd0, 2'd0, 8'h00); #3;
        chk("t1_send", 32'(send_it), 32'd1);
        chk("t1_send_no_timeout", 32'(timeout_err), 32'd0);
        tick(); set_p(0, 1'b0, 1'b0, 3'd3, 2'd2, 8'h55); req = 2'b00; #3;
        chk("t1_sending_grant", 32'(grant), 32'd1);
        chk("t1_sending_quiet", 32'({g_ready_to_load, g_ready_to_send, load_color, pixel_index,
                                      color_index, color_level, send_it}), 32'd0);
        tick(); #3; chk("t1_req_ignored", 32'(grant), 32'd1);
        chk("t1_no_early_done", 32'(g_done), 32'd0);
        tick(); done_wait = 1'b1; #3; chk("t1_done", 32'(g_done), 32'd1);
        tick(); done_wait = 1'b0; #3; chk("t1_release", 32'(grant), 32'd0);
        chk("t1_load_count", 32'(n_loads), 32'd15);
        chk("t1_send_count", 32'(n_sends), 32'd1);

        // 2: both request; pointer now at 1. Send beats simultaneous load.
        req = 2'b11;
        tick(); #3; chk("t2_gap_idle", 32'(grant), 32'd0);
        tick(); set_p(1, 1'b1, 1'b1, 3'd2, 2'd1, 8'h77); #3;
        chk("t2_grant_b", 32'(grant), 32'd2);
        chk("t2_send_wins", 32'({load_color, send_it}), 32'b01);
        tick(); set_p(1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00); done_wait = 1'b1; #3;
        chk("t2_done_b", 32'(g_done), 32'd2);
        tick(); done_wait = 1'b0; #3; chk("t2_release", 32'(grant), 32'd0);
        tick(); #3; chk("t2_idle", 32'(grant), 32'd0);

        // 3: owner 0 loads while producer 1 strobes its own data.
        for (int i = 0; i < 3; i++) begin
            tick();
            set_p(0, 1'b1, 1'b0, 3'(i + 1), 2'(i), 8'(8'h40 + i));
            set_p(1, 1'b1, 1'b0, 3'd2, 2'd2, 8'hEE);
            push(3'(i + 1), 2'(i), 8'(8'h40 + i));
            #3;
            chk("t3_grant_a", 32'(grant), 32'd1);
            chk("t3_rdy_owner_only", 32'(g_ready_to_load), 32'd1);
        end
        tick(); set_p(0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00); #3;
        chk("t3_nonowner_ignored", 32'(load_color), 32'd0);
        tick(); set_p(0, 1'b0, 1'b1, 3'd0, 2'd0, 8'h00); set_p(1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
        #3; chk("t3_send", 32'(send_it), 32'd1);
        tick(); set_p(0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00); done_wait = 1'b1; #3;
        chk("t3_done_a", 32'(g_done), 32'd1);
        tick(); done_wait = 1'b0; #3; chk("t3_release", 32'(grant), 32'd0);
        tick(); #3; chk("t3_idle", 32'(grant), 32'd0);

        // 4: out-of-range index dropped, boundary index forwarded.
        tick(); set_p(1, 1'b1, 1'b0, 3'd5, 2'd0, 8'h12); #3;
        chk("t4_grant_b", 32'(grant), 32'd2);
        chk("t4_bad_dropped", 32'({load_color, bad_pixel}), 32'b01);
        tick(); set_p(1, 1'b1, 1'b0, 3'd4, 2'd2, 8'h34); push(3'd4, 2'd2, 8'h34); #3;
        chk("t4_edge_ok", 32'({load_color, bad_pixel}), 32'b10);
        tick(); set_p(1, 1'b0, 1'b1, 3'd0, 2'd0, 8'h00); #3; chk("t4_send", 32'(send_it), 32'd1);
        tick(); set_p(1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00); done_wait = 1'b1; #3;
        chk("t4_done_b", 32'(g_done), 32'd2);
        tick(); done_wait = 1'b0; #3; chk("t4_release", 32'(grant), 32'd0);
        tick(); #3; chk("t4_idle", 32'(grant), 32'd0);

        // 5: owner 0 stalls; watchdog fires on GRANT cycle 16.
        for (int c = 1; c <= 16; c++) begin
            tick(); #3;
            chk("t5_grant_a", 32'(grant), 32'd1);
            chk("t5_timeout", 32'(timeout_err), 32'(c == 16));
        end
        tick(); #3; chk("t5_revoked", 32'({grant, timeout_err}), 32'd0);
        tick(); #3; chk("t5_idle", 32'(grant), 32'd0);
        tick(); #3; chk("t5_other_granted", 32'(grant), 32'd2);
        tick(); req = 2'b01; #3; chk("t5_drop_no_send", 32'({grant, send_it}), 32'b100);
        tick(); #3; chk("t5_drop_release", 32'(grant), 32'd0);
        tick(); #3; chk("t5_drop_idle", 32'(grant), 32'd0);

        // 6: reset while SENDING aborts without a done pulse.
        tick(); #3; chk("t6_grant_a", 32'(grant), 32'd1);
        tick(); set_p(0, 1'b0, 1'b1, 3'd0, 2'd0, 8'h00); #3; chk("t6_send", 32'(send_it), 32'd1);
        tick(); set_p(0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00); #3;
        chk("t6_sending", 32'(grant), 32'd1);
        #2; reset = 1'b1; #1; chk("t6_async_clear", 32'(all_outs), 32'd0);
        done_wait = 1'b1; #1; chk("t6_no_done", 32'(g_done), 32'd0);
        tick(); chk("t6_reset_held", 32'(all_outs), 32'd0);
        tick(); reset = 1'b0; req = 2'b10; done_wait = 1'b0; #3;
        chk("t6_idle_after_reset", 32'(grant), 32'd0);
        tick(); #3; chk("t6_grant_b", 32'({grant, send_it}), 32'b100);
        tick(); #3; chk("t6_no_replay", 32'({grant, send_it}), 32'b100);

        chk("total_sends", 32'(n_sends), 32'd5);
        chk("total_loads", 32'(n_loads), 32'd19);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
